// File: rtl/crc_serial_pkg.sv
// crc_serial_pkg: shared constants for the serial CRC appender.
// FSM state encodings, USB CRC5/CRC16 polynomials and check residues.
package crc_serial_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [4:0]  CRC5_RES   = 5'h0C;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

  // Counter width able to index MAX_W CRC bits (never below 1).
  function automatic int cnt_width(input int max_w);
    return (max_w > 1) ? $clog2(max_w) : 1;
  endfunction

endpackage

// File: rtl/crc_serial_append_lfsr.sv
// crc_lfsr: serial MSB-first CRC register with a runtime polynomial and width.
// The active width is given as a low-aligned mask; its top set bit is the CRC MSB.
// Reset and init load all ones across MAX_W; the first update masks the unused
// upper bits back to zero, so the start value is all ones for either mode.
module crc_lfsr #(
  parameter int MAX_W = 16
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic [MAX_W-1:0] i_poly,
  input  logic [MAX_W-1:0] i_mask,
  input  logic             i_din,
  input  logic             i_en,
  input  logic             i_init,
  output logic [MAX_W-1:0] o_crc
);

  logic [MAX_W-1:0] r_crc;
  logic             w_msb;
  logic             w_fb;
  logic [MAX_W-1:0] w_next;

  assign w_msb  = |(r_crc & i_mask & ~(i_mask >> 1));
  assign w_fb   = w_msb ^ i_din;
  assign w_next = ((r_crc << 1) ^ (w_fb ? i_poly : '0)) & i_mask;

  // Shift one payload bit into the CRC, or reload the all-ones seed.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)      r_crc <= '1;
    else if (i_init) r_crc <= '1;
    else if (i_en)   r_crc <= w_next;
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_serial_append.sv
// crc_serial_append: passes payload bits through while computing a CRC, then
// appends the complemented CRC MSB-first. Mode A/B selected per packet.
// Optional receive-side check mode under `define CRC_CHECK_EN.
module crc_serial_append
  import crc_serial_pkg::*;
#(
  parameter int               MAX_W  = 16,
  parameter int               W_A    = 5,
  parameter int               W_B    = 16,
  parameter logic [MAX_W-1:0] POLY_A = MAX_W'(CRC5_POLY),
  parameter logic [MAX_W-1:0] POLY_B = MAX_W'(CRC16_POLY)
`ifdef CRC_CHECK_EN
  ,
  parameter logic [MAX_W-1:0] RES_A  = MAX_W'(CRC5_RES),
  parameter logic [MAX_W-1:0] RES_B  = MAX_W'(CRC16_RES)
`endif
) (
  input  logic clk,
  input  logic rst_L,
  input  logic in_bit,
  input  logic in_valid,
  input  logic start,
  input  logic pkt_type,
  input  logic pause_out,
`ifdef CRC_CHECK_EN
  input  logic check,
  output logic crc_done,
  output logic crc_ok,
`endif
  output logic pause_in,
  output logic out_bit,
  output logic out_valid
);

  localparam int CW = cnt_width(MAX_W);
  localparam logic [MAX_W-1:0] MASK_A = {MAX_W{1'b1}} >> (MAX_W - W_A);
  localparam logic [MAX_W-1:0] MASK_B = {MAX_W{1'b1}} >> (MAX_W - W_B);
  localparam logic [CW-1:0]    LAST_A = CW'(W_A - 1);
  localparam logic [CW-1:0]    LAST_B = CW'(W_B - 1);

  logic [1:0]       r_state, w_state_nxt;
  logic             r_mode,  w_mode_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             w_mode;
  logic [MAX_W-1:0] w_poly, w_mask, w_crc;
  logic [CW-1:0]    w_last, w_idx;
  logic             w_en, w_init;
  logic             w_ob, w_ov, w_pi;

  // The mode is live from pkt_type on the first payload cycle, latched after.
  assign w_mode = (r_state == IDLE) ? pkt_type : r_mode;
  assign w_poly = w_mode ? POLY_B : POLY_A;
  assign w_mask = w_mode ? MASK_B : MASK_A;
  assign w_last = w_mode ? LAST_B : LAST_A;
  assign w_idx  = w_last - r_cnt;

  crc_lfsr #(.MAX_W(MAX_W)) u_lfsr (
    .clk    (clk),
    .rst_L  (rst_L),
    .i_poly (w_poly),
    .i_mask (w_mask),
    .i_din  (in_bit),
    .i_en   (w_en),
    .i_init (w_init),
    .o_crc  (w_crc)
  );

`ifdef CRC_CHECK_EN
  logic w_chk_end;
  logic r_done, r_ok;
`endif

  // FSM next state, CRC enable and output mux; payload bypass is combinational.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_en        = 1'b0;
    w_init      = 1'b0;
    w_ob        = in_bit;
    w_ov        = in_valid;
    w_pi        = pause_out;
`ifdef CRC_CHECK_EN
    w_chk_end   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = CALC;
          w_mode_nxt  = pkt_type;
          w_en        = ~start & ~pause_out;
        end
      end
      CALC: begin
        if (in_valid) begin
          w_en = ~start & ~pause_out;
        end else
`ifdef CRC_CHECK_EN
        if (check) begin
          // Receive check: no append, result reported next cycle.
          w_state_nxt = IDLE;
          w_init      = 1'b1;
          w_chk_end   = 1'b1;
        end else
`endif
        begin
          // First CRC bit goes out in the end-of-payload cycle (no bubble).
          w_ob        = ~w_crc[w_last];
          w_ov        = 1'b1;
          w_pi        = 1'b1;
          w_state_nxt = SEND;
          w_cnt_nxt   = '0;
          if (!pause_out) begin
            if (w_last == '0) begin
              w_state_nxt = IDLE;
              w_init      = 1'b1;
            end else begin
              w_cnt_nxt = CW'(1);
            end
          end
        end
      end
      SEND: begin
        w_ob = ~w_crc[w_idx];
        w_ov = 1'b1;
        w_pi = 1'b1;
        if (!pause_out) begin
          if (r_cnt == w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_init      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_init      = 1'b1;
      end
    endcase
  end

  // State, mode latch and CRC bit counter.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef CRC_CHECK_EN
  // One-cycle done pulse; ok holds until the next check completes.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_done <= 1'b0;
      r_ok   <= 1'b0;
    end else begin
      r_done <= w_chk_end;
      if (w_chk_end) r_ok <= ((w_crc & w_mask) == ((w_mode ? RES_B : RES_A) & w_mask));
    end
  end

  assign crc_done = r_done;
  assign crc_ok   = r_ok;
`endif

  // Reset forces outputs low immediately, even while inputs toggle.
  assign out_bit   = rst_L & w_ob;
  assign out_valid = rst_L & w_ov;
  assign pause_in  = rst_L & w_pi;

endmodule

// File: tb/tb_crc_serial_append.sv
// Self-checking bench for crc_serial_append: randomized packets, a polynomial
// long-division reference model and a scoreboard of expected serial output.
module tb_crc_serial_append;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic in_bit = 1'b0, in_valid = 1'b0, start = 1'b0, pkt_type = 1'b0, pause_out = 1'b0;
  logic pause_in, out_bit, out_valid;
`ifdef CRC_CHECK_EN
  logic check = 1'b0;
  logic crc_done, crc_ok;
`endif

  crc_serial_append dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .start     (start),
    .pkt_type  (pkt_type),
    .pause_out (pause_out),
`ifdef CRC_CHECK_EN
    .check     (check),
    .crc_done  (crc_done),
    .crc_ok    (crc_ok),
`endif
    .pause_in  (pause_in),
    .out_bit   (out_bit),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit sb[$];
  bit pkt[$];
  int nstart;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // CRC as the remainder of (M(x)*x^W + ones(x)*x^n) mod G(x), by long division.
  function automatic bit [15:0] model_crc(input bit mode, input bit d[$]);
    int w = mode ? 16 : 5;
    bit [16:0] g = mode ? 17'h18005 : 17'h00025;
    bit a[$];
    bit [15:0] r = '0;
    int n = d.size();
    a = d;
    for (int j = 0; j < w; j++) a.push_back(1'b0);
    for (int j = 0; j < w; j++) a[j] = ~a[j];
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ g[w-j];
    for (int j = 0; j < w; j++) r = {r[14:0], a[n+j]};
    return r;
  endfunction

  // Monitor: every valid output bit must match the head of the scoreboard;
  // the head is only retired when downstream actually consumes it.
  always @(negedge clk) begin
    if (rst_L && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0b expected=none", out_bit);
      end else begin
        chk("out_bit", 32'(out_bit), 32'(sb[0]));
        if (!pause_out) void'(sb.pop_front());
      end
    end
  end

  task automatic build_rand(input int nst, input int nd);
    pkt.delete();
    nstart = nst;
    for (int i = 0; i < nst + nd; i++) pkt.push_back(1'($urandom));
  endtask

  task automatic push_expected(input bit mode, input bit append, output bit [15:0] c);
    bit d[$];
    int w = mode ? 16 : 5;
    for (int i = nstart; i < pkt.size(); i++) d.push_back(pkt[i]);
    c = model_crc(mode, d);
    foreach (pkt[i]) sb.push_back(pkt[i]);
    if (append) for (int j = 0; j < w; j++) sb.push_back(~c[w-1-j]);
  endtask

  // Drive the payload; a paused bit is held until it is taken.
  task automatic drive_payload(input bit mode, input int pmode);
    bit p;
    for (int i = 0; i < pkt.size(); i++) begin
      in_valid = 1'b1;
      in_bit   = pkt[i];
      start    = (i < nstart);
      pkt_type = (i == 0) ? mode : 1'($urandom);
      do begin
        pause_out = (pmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
        p = pause_out;
        @(posedge clk); #1;
      end while (p);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    in_bit   = 1'($urandom);
    pkt_type = 1'($urandom);
  endtask

  // Run until the CRC tail finishes; pmode 2 stalls the 2nd CRC bit 3 cycles.
  task automatic tail(input int pmode, output int pin);
    int c = 0, held = 0, cyc;
    pin = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (pmode == 1)      pause_out = ($urandom_range(0, 2) == 0);
      else if (pmode == 2) pause_out = (c == 1 && held < 3);
      else                 pause_out = 1'b0;
      @(negedge clk);
      if (!out_valid) break;
      if (pause_in) pin++;
      @(posedge clk); #1;
      if (pause_out) held++; else c++;
    end
    if (cyc >= 300) begin
      checks++;
      failures++;
      $display("FAIL tail_timeout actual=%0d expected=<300", cyc);
    end
  endtask

  task automatic run_pkt(input bit mode, input int pmode, input bit chk_en, output int pin);
    bit [15:0] c;
`ifdef CRC_CHECK_EN
    check = chk_en;
`endif
    push_expected(mode, !chk_en, c);
    drive_payload(mode, pmode);
    tail(pmode, pin);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int pin;
    bit [15:0] c;
    // Reset: outputs low even with live inputs.
    in_valid = 1'b1; in_bit = 1'b1; pause_out = 1'b1;
    #2;
    chk("rst_out_bit", 32'(out_bit), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pause_in", 32'(pause_in), 0);
    in_valid = 1'b0; in_bit = 1'b0; pause_out = 1'b0;
    @(posedge clk); #3 rst_L = 1'b1;
    @(posedge clk); #1;

    // Mode A, 11 zero data bits.
    pkt.delete(); nstart = 0;
    repeat (11) pkt.push_back(1'b0);
    run_pkt(1'b0, 0, 1'b0, pin);
    chk("t1_pause_in_cycles", 32'(pin), 32'd5);

    // Mode B zero-length: a single start bit.
    pkt.delete(); nstart = 1; pkt.push_back(1'b1);
    run_pkt(1'b1, 0, 1'b0, pin);
    chk("t2_pause_in_cycles", 32'(pin), 32'd16);

    // Test 1 again with the 2nd CRC bit stalled.
    pkt.delete(); nstart = 0;
    repeat (11) pkt.push_back(1'b0);
    run_pkt(1'b0, 2, 1'b0, pin);
    chk("t3_pause_in_cycles", 32'(pin), 32'd8);

    // Reset during the 3rd CRC bit of mode B, then a clean packet.
    build_rand(1, 8);
    push_expected(1'b1, 1'b1, c);
    drive_payload(1'b1, 0);
    pause_out = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_L = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    #1;
    chk("t4_async_out_bit", 32'(out_bit), 0);
    chk("t4_async_out_valid", 32'(out_valid), 0);
    chk("t4_async_pause_in", 32'(pause_in), 0);
    @(posedge clk); #1 in_valid = 1'b0; in_bit = 1'b0;
    @(posedge clk); #3 rst_L = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    build_rand(1, 12);
    run_pkt(1'b1, 0, 1'b0, pin);
    chk("t4_post_pause_in", 32'(pin), 32'd16);

    // Back-to-back A then B.
    build_rand(2, 11);
    run_pkt(1'b0, 0, 1'b0, pin);
    build_rand(2, 20);
    run_pkt(1'b1, 0, 1'b0, pin);
    chk("t5_b_pause_in", 32'(pin), 32'd16);

    // Randomized packets with random stalls.
    for (int k = 0; k < 24; k++) begin
      build_rand($urandom_range(0, 8), $urandom_range(0, 40));
      run_pkt(1'($urandom), 1, 1'b0, pin);
    end

`ifdef CRC_CHECK_EN
    // Receive check: valid data+CRC, then one flipped bit.
    for (int f = 0; f < 2; f++) begin
      bit d[$];
      bit exp_ok;
      pkt.delete(); nstart = 0;
      repeat (11) pkt.push_back(1'b0);
      pkt.push_back(1'b0); pkt.push_back(1'b1); pkt.push_back(1'b0);
      pkt.push_back(1'b0); pkt.push_back(1'b0);
      if (f == 1) pkt[3] = ~pkt[3];
      d = pkt;
      exp_ok = (model_crc(1'b0, d) == 16'h000C);
      run_pkt(1'b0, 0, 1'b1, pin);
      @(posedge clk); #1;
      chk("t6_crc_done", 32'(crc_done), 1);
      chk("t6_crc_ok", 32'(crc_ok), 32'(exp_ok));
      @(posedge clk); #1;
      chk("t6_done_pulse", 32'(crc_done), 0);
      chk("t6_ok_hold", 32'(crc_ok), 32'(exp_ok));
    end
    check = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
